// File: rtl/mesh_rtr_node.sv
// 2D-mesh router node: XY routing from four input ports into four
// first-word-fall-through output FIFOs through one shared arbiter.
module mesh_rtr_node #(
  parameter int PCKG_SZ    = 40,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_R       = 1,
  parameter int ID_C       = 1,
  parameter int ROWS       = 4,
  parameter int COLUMNS    = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*PCKG_SZ-1:0] data_out_i_in,
  input  logic [3:0]           pndng_i_in,
  output logic [3:0]           popin,
  output logic [4*PCKG_SZ-1:0] data_out,
  output logic [3:0]           pndng,
  input  logic [3:0]           pop,
  output logic [3:0]           fifo_full,
  output logic [7:0]           err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  if (PCKG_SZ < 16 || FIFO_DEPTH < 2 || ID_R < 1 || ID_R > ROWS ||
      ID_C < 1 || ID_C > COLUMNS) begin : g_cfg_err
    $error("mesh_rtr_node: invalid parameter set");
  end

  typedef enum logic {ARB, XFER} state_t;

  // Returns {misroute, port}; column is resolved before row (XY order).
  function automatic logic [2:0] route(input logic [7:0] hdr);
    int row, col;
    row = int'(hdr[7:4]);
    col = int'(hdr[3:0]);
    if (col > ID_C)      route = 3'b001;
    else if (col < ID_C) route = 3'b011;
    else if (row < ID_R) route = 3'b000;
    else if (row > ID_R) route = 3'b010;
    else                 route = 3'b100;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  state_t state_q, state_d;
  logic [1:0]         rr_ptr;
  logic [2:0]         route_r [4];
  logic [3:0]         elig;
  logic [1:0]         sel, idx;
  logic               found;

  logic [1:0]         gnt_p0, tgt_p0;
  logic               mis_p0;
  logic [PCKG_SZ-1:0] pkt_p0;

  logic [PCKG_SZ-1:0] mem    [4][FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr [4];
  logic [PTR_W-1:0]   wr_ptr [4];
  logic [CNT_W-1:0]   cnt    [4];
  logic [3:0]         do_push, do_pop;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      route_r[i] = route(data_out_i_in[i*PCKG_SZ + PCKG_SZ - 8 +: 8]);
      elig[i]    = pndng_i_in[i] && (route_r[i][2] || !fifo_full[route_r[i][1:0]]);
    end
  end

  // Fixed priority is a round-robin scan that always starts at port 0.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = (ARB_MODE == 1) ? 2'(k) : rr_ptr + 2'(k);
      if (!found && elig[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (found) state_d = XFER;
      XFER:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // ---- stage p0: grant registered in ARB, consumed in XFER ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB;
      rr_ptr  <= '0;
      gnt_p0  <= '0;
      tgt_p0  <= '0;
      mis_p0  <= 1'b0;
      err_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && found) begin
        gnt_p0 <= sel;
        tgt_p0 <= route_r[sel][1:0];
        mis_p0 <= route_r[sel][2];
      end
      if (state_q == XFER) begin
        rr_ptr <= gnt_p0 + 2'd1;
        if (mis_p0 && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ARB && found) pkt_p0 <= data_out_i_in[sel*PCKG_SZ +: PCKG_SZ];
  end

  assign popin = (state_q == XFER) ? (4'b0001 << gnt_p0) : 4'b0000;

  always_comb begin
    data_out = '0;
    for (int i = 0; i < 4; i++) begin
      pndng[i]     = (cnt[i] != '0);
      fifo_full[i] = (cnt[i] == DEPTH_C);
      do_pop[i]    = pop[i] && pndng[i];
      do_push[i]   = (state_q == XFER) && !mis_p0 && (tgt_p0 == 2'(i)) && !fifo_full[i];
      if (pndng[i]) data_out[i*PCKG_SZ +: PCKG_SZ] = mem[i][rd_ptr[i]];
    end
  end

  // ---- stage p1: output FIFOs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (do_push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (do_pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        case ({do_push[i], do_pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_push[i]) mem[i][wr_ptr[i]] <= pkt_p0;
    end
  end

endmodule
